wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter for the 32-entry MIPS register file's single write port. Merges three independent write-back sources into one registered write per cycle: ALU, load/store unit, multiply/divide unit. Priority is fixed for the ALU, round-robin between LSU and MDU, and a starvation guard stops the ALU from locking out the other two. It sits between the execute/memory stages and the register file, and it optionally provides a bypass view of the write in flight.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a waiting LSU/MDU request may lose to the ALU before the ALU is held off for one cycle (range 1–15).
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- alu_valid / alu_waddr / alu_wdata  in  1/5/32  ALU write request
- alu_ready  out  1  ALU request accepted this cycle
- lsu_valid / lsu_waddr / lsu_wdata  in  1/5/32  LSU write request
- lsu_ready  out  1  LSU request accepted
- mdu_valid / mdu_waddr / mdu_wdata  in  1/5/32  MDU write request
- mdu_ready  out  1  MDU request accepted
- wen / waddr / wdata  out  1/5/32  register-file write port, registered
- byp_raddr1, byp_raddr2  in  5  decode-stage read addresses (bypass)
- byp_hit1, byp_hit2  out  1  in-flight write matches the read address
- byp_data1, byp_data2  out  32  forwarded data

## Operation
- Handshake: a transfer occurs when valid && ready are both high in the same cycle. Requesters hold their addr/data stable while valid && !ready.
- Grant order: ALU > {LSU, MDU}, unless the guard is active.
  - alu_ready = !guard.
  - lsu_ready = lsu_valid-independent; it is 1 when (guard || !alu_valid) && (!mdu_valid || rr_ptr==LSU).
  - mdu_ready is symmetric, using rr_ptr==MDU.
- rr_ptr: 1 bit, reset value LSU. After an LSU grant it becomes MDU; after an MDU grant it becomes LSU. Otherwise it is unchanged.
- Starvation counter (4 bits, reset 0):
  - Increments in each cycle where an ALU grant occurs while (lsu_valid || mdu_valid).
  - Clears on any LSU/MDU grant, or when no LSU/MDU request is pending.
  - guard = (cnt == STARVE_LIMIT). While guard is high, the waiting source is granted and cnt clears.
- Exactly one grant per cycle at most.
- The winner's addr/data load into the output register with wen=1. With no grant, wen=0 and waddr/wdata hold their previous values.
- r0 rule: a granted request with waddr==0 completes its handshake but loads wen=0.
- Bypass: byp_hitN = wen && (waddr == byp_raddrN) && (byp_raddrN != 0). byp_dataN = byp_hitN ? wdata : 0. Both are combinational from the output register.

## Timing
- Reset: wen=0, waddr=0, wdata=0, rr_ptr=LSU, cnt=0.
  - While rst is high: all readies are 0 and byp_hit* = 0.
- Ready outputs are combinational from the valids, rr_ptr and cnt. There is no combinational path from a source's own valid to its own ready.
- Latency: a request accepted in cycle N drives wen/waddr/wdata during cycle N+1. The register file commits it at the end of N+1.
- Throughput: 1 write/cycle sustained.
- Reset mid-operation: the pending output write is discarded (wen drops immediately, asynchronously). Requesters must re-present their requests.
- Simultaneous LSU+MDU with no ALU: rr_ptr decides the winner; the loser's ready is 0 and it retries next cycle.

## Configuration
- WB_BYPASS_EN defined: the byp_* logic above is present.
- WB_BYPASS_EN undefined: byp_hit1/2 and byp_data1/2 are tied to 0, and byp_raddr1/2 are ignored. Decode must then stall one cycle on a RAW hazard against the in-flight write.

## Structure
- Shared package wb_pkg:
  - REG_ZERO = 5'd0.
  - Source-ID enum: SRC_ALU, SRC_LSU, SRC_MDU.
  - Width constants: REG_AW = 5, REG_DW = 32.
- Sub-module rr_arb2: 2-way round-robin arbiter holding rr_ptr. It takes req[1:0] and a block input; it produces one-hot gnt[1:0]. It updates the pointer on a grant.
- Top level: ALU priority, starvation counter, output register, r0 filter, bypass.

## Test plan
- Reset mid-write: alu_valid, waddr=7, wdata=0x1234 accepted, then rst pulsed in the next cycle → wen=0 immediately; waddr=0 and wdata=0 after reset.
- Single ALU write: alu_valid, waddr=5, wdata=0xDEADBEEF → alu_ready=1 in cycle N; wen=1, waddr=5, wdata=0xDEADBEEF in N+1.
- LSU+MDU contention, no ALU, both held valid for 4 cycles (LSU→r3, MDU→r4) → grants alternate LSU, MDU, LSU, MDU starting from reset; waddr sequence 3, 4, 3, 4.
- Starvation guard, STARVE_LIMIT=4: ALU valid every cycle with lsu_valid held → ALU wins 4 cycles, alu_ready=0 in cycle 5 with the LSU granted, then the ALU resumes.
- r0 write: MDU waddr=0, wdata=0xFFFFFFFF → mdu_ready=1; wen stays 0 next cycle.
- Bypass (WB_BYPASS_EN): in-flight write r9=0xCAFE, byp_raddr1=9, byp_raddr2=0 → byp_hit1=1, byp_data1=0xCAFE, byp_hit2=0. Without the macro → all byp outputs are 0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the register-file write-back arbiter.
//   REG_AW / REG_DW : register address / data widths
//   REG_ZERO        : architectural zero register (writes are dropped)
//   src_e           : identifies which source won the write port
//   PTR_LSU/PTR_MDU : round-robin pointer encodings
//   wb_dbg_t        : internal state exported for observation
package wb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSU = 2'd1,
    SRC_MDU = 2'd2
  } src_e;

  localparam logic [0:0] PTR_LSU = 1'b0;
  localparam logic [0:0] PTR_MDU = 1'b1;

  typedef struct packed {
    logic [0:0] rr_ptr;
    logic [3:0] starve_cnt;
    logic       guard;
  } wb_dbg_t;

  function automatic logic is_reg_zero(input logic [REG_AW-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter between the LSU (index 0) and
// the MDU (index 1).
//   clk, rst  : clock, asynchronous active-high reset
//   req[1:0]  : request lines {mdu, lsu}
//   block     : suppresses both readies (higher-priority winner or reset)
//   rdy[1:0]  : per-source ready; never depends on that source's own req
//   gnt[1:0]  : one-hot grant (rdy & req)
//   ptr       : current round-robin pointer (PTR_LSU / PTR_MDU)
//
// Handshake: a source transfers in a cycle where its req and rdy are
// both high; it keeps its request stable while req && !rdy.
import wb_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       block,
  output logic [1:0] rdy,
  output logic [1:0] gnt,
  output logic [0:0] ptr
);

  logic [0:0] ptr_q;

  // A source is ready when nobody above blocks and either the other
  // source is idle or the pointer favours it.
  always_comb begin
    rdy    = 2'b00;
    rdy[0] = !block && (!req[1] || (ptr_q == PTR_LSU));
    rdy[1] = !block && (!req[0] || (ptr_q == PTR_MDU));
  end

  assign gnt = rdy & req;
  assign ptr = ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_LSU;
    end else if (gnt[0]) begin
      ptr_q <= PTR_MDU;
    end else if (gnt[1]) begin
      ptr_q <= PTR_LSU;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU, LSU and MDU write-back requests onto the single
// register-file write port, one registered write per cycle.
//   STARVE_LIMIT             : ALU wins tolerated against a waiting
//                              LSU/MDU before the ALU is held off a cycle
//   clk, rst                 : clock, asynchronous active-high reset
//   alu_/lsu_/mdu_valid,waddr,wdata : write requests
//   alu_/lsu_/mdu_ready      : request accepted this cycle
//   wen, waddr, wdata        : registered register-file write port
//   byp_raddr1/2             : decode read addresses
//   byp_hit1/2, byp_data1/2  : forwarding of the in-flight write
//   dbg                      : round-robin pointer, starvation count, guard
//
// Handshake: a transfer happens in a cycle where valid && ready are both
// high; requesters hold addr/data stable while valid && !ready. Readies
// are combinational from the valids, pointer and counter, and no ready
// depends on its own source's valid.
//
// Build option: define WB_BYPASS_EN to include the forwarding logic;
// otherwise the byp_* outputs are tied to zero.
import wb_pkg::*;

module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_waddr,
  input  logic [REG_DW-1:0] alu_wdata,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_waddr,
  input  logic [REG_DW-1:0] lsu_wdata,
  output logic              lsu_ready,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_waddr,
  input  logic [REG_DW-1:0] mdu_wdata,
  output logic              mdu_ready,
  output logic              wen,
  output logic [REG_AW-1:0] waddr,
  output logic [REG_DW-1:0] wdata,
  input  logic [REG_AW-1:0] byp_raddr1,
  input  logic [REG_AW-1:0] byp_raddr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [REG_DW-1:0] byp_data1,
  output logic [REG_DW-1:0] byp_data2,
  output wb_dbg_t           dbg
);

  logic [3:0]        starve_cnt;
  logic              guard;
  logic              rr_block;
  logic [1:0]        rr_rdy;
  logic [1:0]        rr_gnt;
  logic [0:0]        rr_ptr;
  logic              alu_gnt;
  logic              lsu_gnt;
  logic              mdu_gnt;
  logic              side_pending;
  logic              win_any;
  src_e              win_src;
  logic [REG_AW-1:0] win_addr;
  logic [REG_DW-1:0] win_data;

  // Guard holds the ALU off for exactly one cycle once the waiting
  // source has lost STARVE_LIMIT times in a row.
  assign guard = (starve_cnt == 4'(STARVE_LIMIT));

  // The ALU only blocks the side arbiter when it is actually requesting.
  assign rr_block = rst || (alu_valid && !guard);

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .req   ({mdu_valid, lsu_valid}),
    .block (rr_block),
    .rdy   (rr_rdy),
    .gnt   (rr_gnt),
    .ptr   (rr_ptr)
  );

  assign alu_ready    = !rst && !guard;
  assign lsu_ready    = rr_rdy[0];
  assign mdu_ready    = rr_rdy[1];

  assign alu_gnt      = alu_valid && alu_ready;
  assign lsu_gnt      = rr_gnt[0];
  assign mdu_gnt      = rr_gnt[1];
  assign side_pending = lsu_valid || mdu_valid;

  // Winner select; grants are mutually exclusive by construction.
  always_comb begin
    win_any  = 1'b0;
    win_src  = SRC_ALU;
    win_addr = '0;
    win_data = '0;
    if (alu_gnt) begin
      win_any = 1'b1;
      win_src = SRC_ALU;
    end else if (lsu_gnt) begin
      win_any = 1'b1;
      win_src = SRC_LSU;
    end else if (mdu_gnt) begin
      win_any = 1'b1;
      win_src = SRC_MDU;
    end
    case (win_src)
      SRC_LSU: begin
        win_addr = lsu_waddr;
        win_data = lsu_wdata;
      end
      SRC_MDU: begin
        win_addr = mdu_waddr;
        win_data = mdu_wdata;
      end
      default: begin
        win_addr = alu_waddr;
        win_data = alu_wdata;
      end
    endcase
  end

  // Starvation counter: counts ALU wins over a waiting side request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (lsu_gnt || mdu_gnt || !side_pending) begin
      starve_cnt <= 4'd0;
    end else if (alu_gnt) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Output register. A write to r0 still completes its handshake but
  // never asserts wen; address and data follow the winner regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (win_any) begin
      wen   <= !is_reg_zero(win_addr);
      waddr <= win_addr;
      wdata <= win_data;
    end else begin
      wen   <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the in-flight write to decode; r0 never matches.
  always_comb begin
    byp_hit1  = wen && (waddr == byp_raddr1) && !is_reg_zero(byp_raddr1);
    byp_hit2  = wen && (waddr == byp_raddr2) && !is_reg_zero(byp_raddr2);
    byp_data1 = byp_hit1 ? wdata : '0;
    byp_data2 = byp_hit2 ? wdata : '0;
  end
`else
  // No forwarding: decode stalls on a RAW hazard with the in-flight write.
  logic unused_byp_raddr;
  assign unused_byp_raddr = ^{byp_raddr1, byp_raddr2};
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

  always_comb begin
    dbg            = '0;
    dbg.rr_ptr     = rr_ptr;
    dbg.starve_cnt = starve_cnt;
    dbg.guard      = guard;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed stimulus for wb_arbiter checked
// against a behavioural model of the grant rules.
import wb_pkg::*;

module tb_wb_arbiter;

  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              alu_valid = 0, lsu_valid = 0, mdu_valid = 0;
  logic [4:0]        alu_waddr = 0, lsu_waddr = 0, mdu_waddr = 0;
  logic [31:0]       alu_wdata = 0, lsu_wdata = 0, mdu_wdata = 0;
  logic              alu_ready, lsu_ready, mdu_ready;
  logic              wen;
  logic [4:0]        waddr;
  logic [31:0]       wdata;
  logic [4:0]        byp_raddr1 = 0, byp_raddr2 = 0;
  logic              byp_hit1, byp_hit2;
  logic [31:0]       byp_data1, byp_data2;
  wb_dbg_t           dbg;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
    .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata), .mdu_ready(mdu_ready),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .byp_raddr1(byp_raddr1), .byp_raddr2(byp_raddr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .dbg(dbg)
  );

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [37:0] exp_q[$];   // {wen, waddr, wdata} expected after each edge

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // lsu_turn: the LSU wins the next LSU/MDU tie.
  // losses  : consecutive ALU wins while an LSU/MDU request waited.
  bit          m_lsu_turn;
  int          m_losses;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          acc_alu, acc_lsu, acc_mdu;   // accepted in the last step
  logic        obs_alu_ready;

  task automatic model_reset();
    m_lsu_turn = 1; m_losses = 0;
    m_wen = 0; m_waddr = 0; m_wdata = 0;
    acc_alu = 0; acc_lsu = 0; acc_mdu = 0;
    exp_q.delete();
  endtask

  // One clock cycle with the inputs currently driven.
  task automatic step();
    bit held_off, r_alu, r_lsu, r_mdu, side_free;
    bit hit1, hit2, win;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [37:0] cur;
    #1;
    held_off  = (m_losses == LIMIT);
    side_free = held_off || !alu_valid;
    r_alu = !held_off;
    r_lsu = side_free && (!mdu_valid || m_lsu_turn);
    r_mdu = side_free && (!lsu_valid || !m_lsu_turn);
    obs_alu_ready = alu_ready;
    check("alu_ready", alu_ready, r_alu);
    check("lsu_ready", lsu_ready, r_lsu);
    check("mdu_ready", mdu_ready, r_mdu);
    check("rr_ptr", dbg.rr_ptr, m_lsu_turn ? 1'b0 : 1'b1);
    check("starve_cnt", dbg.starve_cnt, m_losses);
    hit1 = BYP && m_wen && (m_waddr == byp_raddr1) && (byp_raddr1 != 0);
    hit2 = BYP && m_wen && (m_waddr == byp_raddr2) && (byp_raddr2 != 0);
    check("byp_hit1", byp_hit1, hit1);
    check("byp_hit2", byp_hit2, hit2);
    check("byp_data1", byp_data1, hit1 ? m_wdata : 32'd0);
    check("byp_data2", byp_data2, hit2 ? m_wdata : 32'd0);

    acc_alu = alu_valid && r_alu;
    acc_lsu = !acc_alu && lsu_valid && r_lsu;
    acc_mdu = !acc_alu && !acc_lsu && mdu_valid && r_mdu;
    win = acc_alu || acc_lsu || acc_mdu;
    wa = acc_alu ? alu_waddr : acc_lsu ? lsu_waddr : mdu_waddr;
    wd = acc_alu ? alu_wdata : acc_lsu ? lsu_wdata : mdu_wdata;

    @(posedge clk);
    if (acc_lsu) m_lsu_turn = 0;
    if (acc_mdu) m_lsu_turn = 1;
    if (acc_lsu || acc_mdu || !(lsu_valid || mdu_valid)) m_losses = 0;
    else if (acc_alu) m_losses++;
    if (win) begin
      m_wen = (wa != 0); m_waddr = wa; m_wdata = wd;
    end else begin
      m_wen = 0;
    end
    exp_q.push_back({m_wen, m_waddr, m_wdata});

    @(negedge clk);
    cur = exp_q.pop_front();
    check("wen", wen, cur[37]);
    check("waddr", waddr, cur[36:32]);
    check("wdata", wdata, cur[31:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md);
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
  endtask

  task automatic apply_reset();
    rst = 1;
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 5'd3, 32'h3);
    byp_raddr1 = 5'd1; byp_raddr2 = 5'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_lsu_ready", lsu_ready, 1'b0);
    check("rst_mdu_ready", mdu_ready, 1'b0);
    check("rst_wen", wen, 1'b0);
    check("rst_waddr", waddr, 5'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_byp_hit1", byp_hit1, 1'b0);
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    byp_raddr1 = 0; byp_raddr2 = 0;
    model_reset();
  endtask

  // Keep an unaccepted request stable; otherwise pick a fresh one.
  task automatic rand_drive(input int p_alu, input int p_side);
    if (!(alu_valid && !acc_alu)) begin
      alu_valid = ($urandom_range(0, 99) < p_alu);
      alu_waddr = 5'($urandom_range(0, 7)); alu_wdata = $urandom;
    end
    if (!(lsu_valid && !acc_lsu)) begin
      lsu_valid = ($urandom_range(0, 99) < p_side);
      lsu_waddr = 5'($urandom_range(0, 7)); lsu_wdata = $urandom;
    end
    if (!(mdu_valid && !acc_mdu)) begin
      mdu_valid = ($urandom_range(0, 99) < p_side);
      mdu_waddr = 5'($urandom_range(0, 7)); mdu_wdata = $urandom;
    end
    byp_raddr1 = 5'($urandom_range(0, 7));
    byp_raddr2 = 5'($urandom_range(0, 7));
  endtask

  // ---------------- test sequence ----------------
  logic [4:0] pair_addr [4];
  bit         starve_pat[6];

  initial begin
    pair_addr  = '{5'd3, 5'd4, 5'd3, 5'd4};
    starve_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();

    // Reset in the cycle after an accepted write.
    drive(1, 5'd7, 32'h1234, 0, 0, 0, 0, 0, 0);
    step();
    check("midrst_wen_before", wen, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    byp_raddr1 = 5'd7;
    rst = 1;
    #1;
    check("midrst_wen", wen, 1'b0);
    check("midrst_waddr", waddr, 5'd0);
    check("midrst_wdata", wdata, 32'd0);
    check("midrst_alu_ready", alu_ready, 1'b0);
    check("midrst_byp_hit1", byp_hit1, 1'b0);
    @(negedge clk);
    rst = 0;
    byp_raddr1 = 0;
    model_reset();

    // Single ALU write.
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    step();
    check("alu_wr_wen", wen, 1'b1);
    check("alu_wr_waddr", waddr, 5'd5);
    check("alu_wr_wdata", wdata, 32'hDEADBEEF);

    // LSU/MDU contention without the ALU.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 5'd3, 32'h300 + i, 1, 5'd4, 32'h400 + i);
      step();
      check("rr_waddr", waddr, pair_addr[i]);
    end

    // Starvation guard: ALU every cycle, LSU waiting.
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'd10 + 5'(i), 32'hA0 + i, (i < 5), 5'd3, 32'h33, 0, 0, 0);
      step();
      check("starve_alu_ready", obs_alu_ready, starve_pat[i]);
      if (i == 4) check("starve_lsu_win", waddr, 5'd3);
    end

    // r0 write from the MDU.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    step();
    check("r0_wen", wen, 1'b0);

    // Bypass of an in-flight r9 write.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'hCAFE);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    byp_raddr1 = 5'd9; byp_raddr2 = 5'd0;
    #1;
    check("byp9_hit1", byp_hit1, BYP);
    check("byp9_data1", byp_data1, BYP ? 32'hCAFE : 32'd0);
    check("byp9_hit2", byp_hit2, 1'b0);
    step();

    // Randomized traffic, heavy and light ALU phases.
    for (int i = 0; i < 400; i++) begin
      rand_drive(i < 200 ? 85 : 40, i < 200 ? 50 : 60);
      step();
    end

    // Random reset mid-traffic, then more traffic.
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      rand_drive(60, 60);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
